// File: rtl/fir_filter.sv
// Streaming direct-form FIR filter with a one-deep valid/ready output register.
// Optional window flush port enabled by defining FIR_FILTER_FLUSH_EN.
module fir_filter #(
    parameter int width_p = 24,
    parameter int depth_p = 4
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
`ifdef FIR_FILTER_FLUSH_EN
    input  logic                                    flush_i,
`endif
    input  logic [width_p-1:0]                      data_i,
    input  logic                                    valid_i,
    output logic                                    ready_o,
    input  logic [depth_p*width_p-1:0]              coeff_i,
    output logic                                    valid_o,
    output logic [2*width_p+$clog2(depth_p)-1:0]    data_o,
    input  logic                                    ready_i
);
    localparam int out_w_lp = 2*width_p + $clog2(depth_p);

    logic                        w_in_hs;
    logic                        w_out_hs;
    logic                        w_flush;
    logic                        r_valid;
    logic [out_w_lp-1:0]         r_data;
    logic signed [width_p-1:0]   r_window      [depth_p];
    logic signed [width_p-1:0]   w_window_next [depth_p];
    logic signed [out_w_lp-1:0]  w_prod        [depth_p];
    logic signed [out_w_lp-1:0]  w_acc         [depth_p+1];

`ifdef FIR_FILTER_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    assign ready_o  = ~r_valid | ready_i;
    assign w_in_hs  = valid_i & ready_o;
    assign w_out_hs = r_valid & ready_i;
    assign valid_o  = r_valid;
    assign data_o   = r_data;
    assign w_acc[0] = '0;

    // The sum is formed from the post-shift window so the result registered on a
    // handshake already includes the sample being accepted.
    genvar gi;
    generate
        for (gi = 0; gi < depth_p; gi++) begin : g_tap
            logic signed [width_p-1:0] w_coeff;
            assign w_coeff = coeff_i[gi*width_p +: width_p];

            if (gi == 0) begin : g_newest
                assign w_window_next[gi] = w_in_hs ? $signed(data_i)
                                         : (w_flush ? '0 : r_window[gi]);
            end else begin : g_older
                assign w_window_next[gi] = w_flush ? '0
                                         : (w_in_hs ? r_window[gi-1] : r_window[gi]);
            end

            // Operands widened first so the product and running sum never wrap.
            assign w_prod[gi]  = $signed(out_w_lp'(w_window_next[gi]))
                               * $signed(out_w_lp'(w_coeff));
            assign w_acc[gi+1] = w_acc[gi] + w_prod[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            for (int k = 0; k < depth_p; k++) begin
                r_window[k] <= '0;
            end
        end else begin
            if (w_in_hs) begin
                r_valid <= 1'b1;
                r_data  <= w_acc[depth_p];
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
            for (int k = 0; k < depth_p; k++) begin
                r_window[k] <= w_window_next[k];
            end
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter (width 8, depth 4) against a sample-history model.
module tb_fir_filter;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int OW = 2*W + $clog2(D);

    logic            clk = 1'b0;
    logic            reset_i;
    logic [W-1:0]    data_i;
    logic            valid_i;
    logic            ready_o;
    logic [D*W-1:0]  coeff_i;
    logic            valid_o;
    logic [OW-1:0]   data_o;
    logic            ready_i;
`ifdef FIR_FILTER_FLUSH_EN
    logic            flush_i;
`endif

    int checks = 0;
    int errors = 0;
    int hist[$];
    logic [OW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fir_filter #(.width_p(W), .depth_p(D)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
`ifdef FIR_FILTER_FLUSH_EN
        .flush_i (flush_i),
`endif
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .coeff_i (coeff_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    // Output n = sum_k c_k * sample[n-k], with samples before the start taken as 0.
    function automatic logic [OW-1:0] model_accept(input logic [W-1:0] x, input logic [D*W-1:0] c);
        longint s;
        logic signed [W-1:0] ck;
        s = 0;
        hist.push_front(int'($signed(x)));
        if (hist.size() > D) void'(hist.pop_back());
        for (int k = 0; k < hist.size(); k++) begin
            ck = c[k*W +: W];
            s += longint'(ck) * longint'(hist[k]);
        end
        return OW'(s);
    endfunction

    function automatic logic [D*W-1:0] mkc(input int c0, input int c1, input int c2, input int c3);
        return {W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        tick();
        reset_i = 1'b0;
        hist.delete();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'd5;
        ready_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        valid_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset valid_o=%b data_o=%0d ready_o=%b expected 0 0 1", valid_o, data_o, ready_o);
        end
        hist.delete();
    endtask

    task automatic test_impulse();
        int exp_v[5] = '{1, 2, 3, 4, 0};
        do_reset();
        coeff_i = mkc(1, 2, 3, 4);
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            data_i  = (i == 0) ? 8'd1 : 8'd0;
            tick();
            checks++;
            if (valid_o !== 1'b1 || data_o !== OW'(exp_v[i])) begin
                errors++;
                $display("FAIL impulse[%0d] valid_o=%b data_o=%0d expected 1 %0d", i, valid_o, data_o, exp_v[i]);
            end
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL impulse_drain valid_o=%b expected 0", valid_o);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        coeff_i = mkc(1, 2, 3, 4);
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'd5;
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== OW'(5)) begin
            errors++;
            $display("FAIL bp_first valid_o=%b data_o=%0d expected 1 5", valid_o, data_o);
        end
        data_i  = 8'd6;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            coeff_i = (i == 1) ? mkc(9, 9, 9, 9) : mkc(1, 2, 3, 4);
            #1;
            checks++;
            if (ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d] ready_o=%b expected 0", i, ready_o);
            end
            tick();
            checks++;
            if (valid_o !== 1'b1 || data_o !== OW'(5)) begin
                errors++;
                $display("FAIL bp_hold[%0d] valid_o=%b data_o=%0d expected 1 5", i, valid_o, data_o);
            end
        end
        coeff_i = mkc(1, 2, 3, 4);
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release ready_o=%b expected 1", ready_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== OW'(16)) begin
            errors++;
            $display("FAIL bp_second valid_o=%b data_o=%0d expected 1 16", valid_o, data_o);
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain valid_o=%b expected 0", valid_o);
        end
    endtask

    task automatic test_signed_extremes();
        longint e;
        do_reset();
        coeff_i = mkc(-128, -128, -128, -128);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = 8'h80;
            tick();
            e = 16384 * (i + 1);
            checks++;
            if (valid_o !== 1'b1 || data_o !== OW'(e)) begin
                errors++;
                $display("FAIL extreme[%0d] data_o=%0d expected %0d", i, $signed(data_o), e);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        int exp_v[2] = '{1, 3};
        do_reset();
        coeff_i = mkc(1, 2, 3, 4);
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1;
            data_i  = 8'd1;
            tick();
            checks++;
            if (data_o !== OW'(exp_v[i])) begin
                errors++;
                $display("FAIL midrst_pre[%0d] data_o=%0d expected %0d", i, data_o, exp_v[i]);
            end
        end
        reset_i = 1'b1;
        data_i  = 8'd7;
        tick();
        reset_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after valid_o=%b data_o=%0d ready_o=%b expected 0 0 1", valid_o, data_o, ready_o);
        end
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'd1;
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== OW'(1)) begin
            errors++;
            $display("FAIL midrst_next valid_o=%b data_o=%0d expected 1 1", valid_o, data_o);
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_random_stalls();
        int accepted = 0;
        int produced = 0;
        int cycles   = 0;
        logic [OW-1:0] e;
        do_reset();
        exp_q.delete();
        while ((accepted < 1000 || exp_q.size() > 0) && cycles < 30000) begin
            valid_i = (accepted < 1000) && ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 7);
            data_i  = W'($urandom);
            coeff_i = $urandom;
            #1;
            checks++;
            if (ready_o !== (~valid_o | ready_i)) begin
                errors++;
                $display("FAIL rand_ready cycle %0d ready_o=%b expected %b", cycles, ready_o, ~valid_o | ready_i);
            end
            if (valid_o === 1'b1 && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra cycle %0d data_o=%0d expected no output", cycles, data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin
                        errors++;
                        $display("FAIL rand_data out %0d data_o=%0d expected %0d", produced, $signed(data_o), $signed(e));
                    end
                end
                produced++;
            end
            if (valid_i && ready_o === 1'b1) begin
                exp_q.push_back(model_accept(data_i, coeff_i));
                accepted++;
            end
            tick();
            cycles++;
        end
        valid_i = 1'b0;
        checks++;
        if (accepted != 1000 || produced != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count accepted=%0d produced=%0d pending=%0d expected 1000 1000 0", accepted, produced, exp_q.size());
        end
    endtask

`ifdef FIR_FILTER_FLUSH_EN
    task automatic test_flush();
        do_reset();
        coeff_i = mkc(1, 2, 3, 4);
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1;
            data_i  = 8'd1;
            tick();
        end
        flush_i = 1'b1;
        data_i  = 8'd2;
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== OW'(2)) begin
            errors++;
            $display("FAIL flush_hs valid_o=%b data_o=%0d expected 1 2", valid_o, data_o);
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== OW'(2)) begin
            errors++;
            $display("FAIL flush_hold valid_o=%b data_o=%0d expected 1 2", valid_o, data_o);
        end
        flush_i = 1'b0;
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'd3;
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== OW'(3)) begin
            errors++;
            $display("FAIL flush_after valid_o=%b data_o=%0d expected 1 3", valid_o, data_o);
        end
        valid_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        coeff_i = '0;
`ifdef FIR_FILTER_FLUSH_EN
        flush_i = 1'b0;
`endif
        test_reset();
        test_impulse();
        test_backpressure();
        test_signed_extremes();
        test_mid_reset();
        test_random_stalls();
`ifdef FIR_FILTER_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
